// File: rtl/gcd_result_checker.sv
// gcd_result_checker: sequential subtract-only check that a claimed g equals gcd(a, b)
// Ports: clk, rst_n (async active-low); start/a/b/g request a check;
//   busy (check in progress), done (verdict pulse), pass/reason (verdict, held).
// Optional: define GCD_CHK_CYCLE_CNT_EN to add the cycles output (accept-to-done count).
module gcd_result_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       reason
`ifdef GCD_CHK_CYCLE_CNT_EN
  ,
  output logic [WIDTH+1:0] cycles
`endif
);
  typedef enum logic [2:0] {IDLE, ZERO, DIV_A, DIV_B, COPRIME, DECIDE, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, rg, qa, qb, res;
  logic accept, cop_end;
  assign accept = (state == IDLE) && start;
  assign cop_end = (qa == '0) || (qb == '0) || (qa == qb);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ((g == '0) ? ZERO : DIV_A) : IDLE;
      ZERO:    state_nx = DONE;
      DIV_A:   state_nx = (ra >= rg) ? DIV_A : (ra != '0) ? DONE : DIV_B;
      DIV_B:   state_nx = (rb >= rg) ? DIV_B : (rb != '0) ? DONE : COPRIME;
      COPRIME: state_nx = cop_end ? DECIDE : COPRIME;
      DECIDE:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // done and busy are registered, so done appears in the IDLE cycle after DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      rg <= '0;
      qa <= '0;
      qb <= '0;
      res <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      reason <= 2'b00;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          rg <= g;
          qa <= '0;
          qb <= '0;
          busy <= 1'b1;
        end
        ZERO: begin
          pass <= (ra == '0) && (rb == '0);
          reason <= ((ra == '0) && (rb == '0)) ? 2'b00 : 2'b11;
        end
        DIV_A: if (ra >= rg) begin
          ra <= ra - rg;
          qa <= qa + 1'b1;
        end else if (ra != '0) begin
          pass <= 1'b0;
          reason <= 2'b01;
        end
        DIV_B: if (rb >= rg) begin
          rb <= rb - rg;
          qb <= qb + 1'b1;
        end else if (rb != '0) begin
          pass <= 1'b0;
          reason <= 2'b01;
        end
        COPRIME: if (qa == '0) res <= qb;
          else if (qb == '0) res <= qa;
          else if (qa == qb) res <= qa;
          else if (qa > qb) qa <= qa - qb;
          else qb <= qb - qa;
        DECIDE: begin
          pass <= (res == WIDTH'(1));
          reason <= (res == WIDTH'(1)) ? 2'b00 : 2'b10;
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
`ifdef GCD_CHK_CYCLE_CNT_EN
  // Preloaded with 2: the accept cycle and the final cycle where done is visible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cycles <= '0;
    else if (accept) cycles <= (WIDTH+2)'(2);
    else if (state != IDLE) cycles <= cycles + 1'b1;
`endif
endmodule

// File: tb/tb_gcd_result_checker.sv
// tb_gcd_result_checker: directed plus random checks of gcd_result_checker against an arithmetic model
module tb_gcd_result_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] a = '0, b = '0, g = '0;
  logic busy, done, pass;
  logic [1:0] reason;
  int tests = 0;
  int fails = 0;
`ifdef GCD_CHK_CYCLE_CNT_EN
  logic [9:0] cycles;
`endif
  gcd_result_checker #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .g(g),
    .busy(busy),
    .done(done),
    .pass(pass),
    .reason(reason)
`ifdef GCD_CHK_CYCLE_CNT_EN
    ,
    .cycles(cycles)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int ugcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  // Verdict from the divisibility/coprime criterion; latency counted in clock edges
  // from the accepting edge to the edge after which done is visible.
  task automatic model(input int ta, input int tb_, input int tg, output logic ep,
                       output logic [1:0] er, output int el);
    int x, y, s;
    if (tg == 0) begin
      ep = (ta == 0 && tb_ == 0);
      er = ep ? 2'b00 : 2'b11;
      el = 3;
    end else if (ta % tg != 0) begin
      ep = 1'b0;
      er = 2'b01;
      el = 3 + ta / tg;
    end else if (tb_ % tg != 0) begin
      ep = 1'b0;
      er = 2'b01;
      el = 4 + ta / tg + tb_ / tg;
    end else begin
      ep = (ugcd(ta / tg, tb_ / tg) == 1);
      er = ep ? 2'b00 : 2'b10;
      x = ta / tg;
      y = tb_ / tg;
      s = 1;
      while (x != 0 && y != 0 && x != y) begin
        if (x > y) x -= y;
        else y -= x;
        s++;
      end
      el = 5 + ta / tg + tb_ / tg + s;
    end
  endtask
  task automatic do_check(input int ta, input int tb_, input int tg);
    logic ep;
    logic [1:0] er;
    int el, n;
    model(ta, tb_, tg, ep, er, el);
    @(negedge clk);
    start = 1'b1;
    a = 8'(ta);
    b = 8'(tb_);
    g = 8'(tg);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("busy_after_accept", busy, 1);
    while (!done && n < 3000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("latency", n, el);
    chk("pass", pass, ep);
    chk("reason", reason, er);
    chk("busy_at_done", busy, 0);
`ifdef GCD_CHK_CYCLE_CNT_EN
    chk("cycles", cycles, el + 1);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("pass_hold", pass, ep);
    chk("reason_hold", reason, er);
  endtask
  initial begin
    int n, ga, mul;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_reason", reason, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_check(4, 0, 4);
    do_check(22, 33, 11);
    do_check(45, 81, 9);
    do_check(45, 81, 3);
    do_check(22, 33, 2);
    do_check(0, 0, 0);
    do_check(5, 0, 0);
    do_check(0, 0, 7);
    do_check(128, 64, 64);
    // abort a running check with reset
    @(negedge clk);
    start = 1'b1;
    a = 8'd128;
    b = 8'd64;
    g = 8'd64;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_abort", n, 0);
    do_check(22, 33, 11);
    // start held high: back-to-back checks with one IDLE/done cycle between
    @(negedge clk);
    start = 1'b1;
    a = 8'd22;
    b = 8'd33;
    g = 8'd11;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end while (!done && n < 3000);
      chk("held_latency", n, 13);
      chk("held_pass", pass, 1);
`ifdef GCD_CHK_CYCLE_CNT_EN
      chk("held_cycles", cycles, 14);
`endif
      if (k == 1) start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("held_done_pulse", done, 0);
    chk("held_idle_busy", busy, 0);
    for (int i = 0; i < 40; i++) begin
      ga = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) begin
        do_check($urandom_range(0, 255), $urandom_range(0, 255), ga);
      end else begin
        mul = $urandom_range(0, 20);
        do_check(ga * mul, ga * $urandom_range(0, 20), ga);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gcd_result_checker.md
Name: gcd_result_checker

Overview:
- Consumer-side checker for the GCD datapath. It takes an operand pair (a, b) and a claimed result g, then decides sequentially whether g == gcd(a, b).
- Criterion: g divides both a and b, and gcd(a/g, b/g) == 1.
- Used in self-checking benches and as an optional on-chip monitor behind the GCD unit.
- Arithmetic is subtract-only: no multiplier, no divider.

Parameters:
- WIDTH, 8, bit width of a, b, g and all internal quotient/remainder registers.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a check; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- g  input  WIDTH  claimed GCD; captured on accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a verdict is ready.
- pass  output  1  verdict; valid from done, held until the next accepted start.
- reason  output  2  00 OK, 01 NOT_DIVISOR, 10 NOT_COPRIME, 11 ZERO_CASE_FAIL; held like pass.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - busy = 0, done = 0, pass = 0, reason = 00.
  - All internal registers = 0.
  - Reset mid-check aborts it; no done is produced.
- IDLE:
  - start = 1 captures a, b, g into ra, rb, rg; clears qa and qb.
  - If g == 0, go to ZERO. Otherwise go to DIV_A.
  - start is ignored in every other state.
- ZERO (1 cycle):
  - pass = (a == 0 && b == 0).
  - reason = 00 on pass, 11 otherwise.
  - Go to DONE.
- DIV_A: one subtraction per cycle.
  - If ra >= rg: ra <= ra - rg, qa <= qa + 1.
  - Otherwise, if ra != 0: pass = 0, reason = 01, go to DONE.
  - Otherwise go to DIV_B.
- DIV_B: same procedure on rb/qb; on zero remainder go to COPRIME.
- COPRIME: subtractive GCD on (qa, qb), one step per cycle.
  - If qa == 0: result = qb, go to DECIDE.
  - Else if qb == 0: result = qa, go to DECIDE.
  - Else if qa == qb: result = qa, go to DECIDE.
  - Else subtract the smaller from the larger.
- DECIDE (1 cycle): pass = (result == 1); reason = 00 on pass, 10 otherwise.
- DONE (1 cycle): done = 1, busy = 0; return to IDLE.
- Latency:
  - Accepted start to done = 2 + (a/g) + 1 + (b/g) + 1 + coprime steps + 1 cycles.
  - The g == 0 path is exactly 3 cycles.
  - Worst case is bounded by 3 × 2^WIDTH + 4.
- Width rules:
  - qa and qb are WIDTH bits; they cannot overflow because g >= 1.
  - Subtraction happens only when the minuend >= the subtrahend, so there is no wrap.
- Simultaneous events:
  - start asserted in the DONE cycle is ignored.
  - start is accepted in the following IDLE cycle if still high.
- pass/reason update only at verdict time, so they remain stable across IDLE.

Optional Feature:
- Macro GCD_CHK_CYCLE_CNT_EN.
- When defined:
  - Adds output cycles [WIDTH+2-1:0].
  - Counts cycles from the accepted start through the verdict, inclusive of the DONE cycle.
  - Cleared on accepted start; holds its value alongside pass; reset to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- a=4, b=0, g=4 -> pass=1, reason=00 (coprime of (1,0) resolves to 1).
- a=128, b=64, g=64 -> pass=1, reason=00; a=22, b=33, g=11 -> pass=1, reason=00; a=45, b=81, g=9 -> pass=1, reason=00.
- a=45, b=81, g=3 -> pass=0, reason=10 (quotients 15 and 27 share 3); a=22, b=33, g=2 -> pass=0, reason=01 (33 mod 2 = 1).
- g=0 cases:
  - a=0, b=0, g=0 -> pass=1, reason=00, done exactly 3 cycles after start.
  - a=5, b=0, g=0 -> pass=0, reason=11.
  - a=0, b=0, g=7 -> pass=0, reason=10.
- Start a=128, b=64, g=64, then pull rst_n low 5 cycles later -> busy, done and pass go to 0 immediately; no done follows; a new check of 22/33/11 afterwards passes.
- start held high continuously -> exactly one done per check, verdicts back-to-back with an IDLE cycle between them; with GCD_CHK_CYCLE_CNT_EN, 22/33/11 reports cycles = 14.
